glb_mcast_driver: RTL and testbench
===================================

GLB_MCAST_DRIVER -- requirements
Module: glb_mcast_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bus payload width.
REQ-002 SHALL have parameter NUM_ROW, default 4, meaning maximum PE rows addressed.
REQ-003 SHALL have parameter NUM_COL, default 4, meaning maximum PE columns addressed.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning staging FIFO entries; power of two, minimum 2.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle pulse that latches cfg_rows and cfg_cols and begins a tile.
REQ-008 SHALL have port abort, input, 1, meaning cancel the tile in progress.
REQ-009 SHALL have ports cfg_rows and cfg_cols, input, $clog2(NUM_ROW)+1 and $clog2(NUM_COL)+1, meaning tile size; valid range 1..NUM_ROW and 1..NUM_COL.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH), meaning the upstream word stream.
REQ-011 SHALL have ports bus_valid (output, 1), bus_ready (input, 1; AND of all MultiCaster readies), bus_data (output, DATA_WIDTH), bus_row_id (output, max(1,$clog2(NUM_ROW))) and bus_col_id (output, max(1,$clog2(NUM_COL))), meaning the tagged multicast bus.
REQ-012 SHALL have ports busy (output, 1), meaning state is RUN, and done (output, 1), meaning a one-cycle tile-complete pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur on start when both cfg values are nonzero; start with any zero cfg value SHALL be ignored.
REQ-015 In RUN, start SHALL be ignored.
REQ-016 A handshake SHALL occur on any cycle with valid && ready on that side.
REQ-017 in_ready SHALL equal (state==RUN) && !fifo_full && (accepted < cfg_rows*cfg_cols); a same-cycle pop SHALL NOT free a slot for a push.
REQ-018 bus_valid SHALL equal (state==RUN) && !fifo_empty; bus_data SHALL be the FIFO head.
REQ-019 A word accepted in cycle N SHALL appear on bus_data no earlier than cycle N+1.
REQ-020 bus_valid, bus_data and the tags SHALL remain stable while bus_valid && !bus_ready.
REQ-021 The tag counters SHALL start at row 0, col 0; each bus handshake SHALL increment col, and col==cfg_cols-1 SHALL wrap col to 0 and increment row.
REQ-022 A bus handshake with row==cfg_rows-1 and col==cfg_cols-1 SHALL move the FSM to DONE; done SHALL be 1 for that single state, then the FSM SHALL return to IDLE.
REQ-023 abort SHALL have priority over every other event: the FIFO, the accept counter and the tag counters SHALL clear and the FSM SHALL go to IDLE next cycle with no done pulse; abort in IDLE SHALL have no effect.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged.

Reset
REQ-025 Asserting rstn low SHALL immediately force IDLE, an empty FIFO, zeroed counters, and in_ready=0, bus_valid=0, bus_data=0, bus_row_id=0, bus_col_id=0, busy=0, done=0.
REQ-026 Reset asserted mid-tile SHALL discard all buffered words; after release the block SHALL wait for a new start.

Configuration
REQ-027 With macro GLB_DRV_STALL_CNT_EN defined, the block SHALL add output stall_cnt (32 bits): it clears on start and on reset, increments each cycle of bus_valid && !bus_ready, and saturates at all-ones.
REQ-028 Without GLB_DRV_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Verification
REQ-029 cfg 2x3, start, feed 6 words 0x11..0x16, bus_ready=1 -> tags (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with data in order, then one done pulse and IDLE.
REQ-030 FIFO_DEPTH=4, bus_ready=0, in_valid=1 for 8 cycles -> exactly 4 words accepted, in_ready=0; bus_data held at the first word.
REQ-031 cfg 1x1 and 16 words offered -> one accepted, in_ready=0 afterward, done one cycle after the bus handshake.
REQ-032 abort after 3 of 6 transfers -> bus_valid=0 next cycle, no done, tags 0; a new start restarts at (0,0).
REQ-033 start with cfg_cols=0 -> stays IDLE, busy=0; start during RUN -> cfg unchanged.
REQ-034 With GLB_DRV_STALL_CNT_EN defined, 5 cycles of bus_ready=0 while bus_valid=1 -> stall_cnt=5.

Source files
------------

// File: rtl/glb_mcast_driver.sv
// ---------------------------------------------------------------------------
// glb_mcast_driver
//
// Streams one tile of words from the global buffer onto a tagged multicast
// bus. Each word passes through a small staging FIFO. As each word leaves,
// it is tagged with its (row, col) position in the tile. The tile runs in
// row-major order and is sized by cfg_rows x cfg_cols, which are latched
// when start is accepted.
//
// Optional feature: define GLB_DRV_STALL_CNT_EN to add a 32-bit saturating
// count of bus stall cycles (bus_valid && !bus_ready).
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   start, abort        begin a tile / cancel the tile in progress
//   cfg_rows, cfg_cols  tile size, sampled when start is accepted
//   in_valid/in_ready/in_data                upstream word stream
//   bus_valid/bus_ready/bus_data             multicast bus
//   bus_row_id/bus_col_id                    tags for the current bus word
//   busy                tile in progress
//   done                one-cycle tile-complete pulse
//   stall_cnt           bus stall cycle count (GLB_DRV_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module glb_mcast_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic [$clog2(NUM_ROW):0]                      cfg_rows,
  input  logic [$clog2(NUM_COL):0]                      cfg_cols,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  output logic                                          bus_valid,
  input  logic                                          bus_ready,
  output logic [DATA_WIDTH-1:0]                         bus_data,
  output logic [((NUM_ROW > 1) ? $clog2(NUM_ROW) : 1)-1:0] bus_row_id,
  output logic [((NUM_COL > 1) ? $clog2(NUM_COL) : 1)-1:0] bus_col_id,
  output logic                                          busy,
  output logic                                          done
`ifdef GLB_DRV_STALL_CNT_EN
  ,
  output logic [31:0]                                   stall_cnt
`endif
);

  localparam int CR_W  = $clog2(NUM_ROW) + 1;
  localparam int CC_W  = $clog2(NUM_COL) + 1;
  localparam int RID_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int CID_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = $clog2(NUM_ROW * NUM_COL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CR_W-1:0]         cfg_rows_q;
  logic [CC_W-1:0]         cfg_cols_q;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [ACC_W-1:0]        accepted;
  logic [ACC_W-1:0]        total;
  logic [RID_W-1:0]        row_q;
  logic [CID_W-1:0]        col_q;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop;
  logic                    start_ok, last_beat, clear;
  logic                    col_last, row_last;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign total      = ACC_W'(cfg_rows_q) * ACC_W'(cfg_cols_q);

  // Fullness comes from the registered count, so a pop in the same cycle
  // never opens a slot for a push.
  assign in_ready  = (state_q == S_RUN) && !fifo_full && (accepted < total);
  assign bus_valid = (state_q == S_RUN) && !fifo_empty;
  assign bus_data  = bus_valid ? mem[rd_ptr] : '0;
  assign bus_row_id = row_q;
  assign bus_col_id = col_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  assign push  = in_valid && in_ready;
  assign pop   = bus_valid && bus_ready;
  assign clear = (state_q == S_RUN) && abort;

  assign col_last = (CC_W'(col_q) == cfg_cols_q - CC_W'(1));
  assign row_last = (CR_W'(row_q) == cfg_rows_q - CR_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Abort wins over completion. A start with a zero
  // dimension is dropped in IDLE.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (cfg_rows != '0) && (cfg_cols != '0)) begin
          state_d  = S_RUN;
          start_ok = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pop && row_last && col_last) begin
          state_d   = S_DONE;
          last_beat = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tile size is captured only when a tile actually starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_rows_q <= '0;
      cfg_cols_q <= '0;
    end else if (start_ok) begin
      cfg_rows_q <= cfg_rows;
      cfg_cols_q <= cfg_cols;
    end
  end

  // FIFO storage. It needs no reset because the output is gated by
  // bus_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy. Abort empties the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Accept counter and row-major tag counters. The tags return to (0,0)
  // after the final beat, so the next tile starts from a known position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accepted <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else if (clear || start_ok) begin
      accepted <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      if (push) accepted <= accepted + ACC_W'(1);
      if (last_beat) begin
        row_q <= '0;
        col_q <= '0;
      end else if (pop) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + RID_W'(1);
        end else begin
          col_q <= col_q + CID_W'(1);
        end
      end
    end
  end

`ifdef GLB_DRV_STALL_CNT_EN
  // Stall counter. It restarts with each accepted tile and saturates at
  // all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (bus_valid && !bus_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_glb_mcast_driver.sv
// ---------------------------------------------------------------------------
// tb_glb_mcast_driver
//
// Self-checking bench for glb_mcast_driver with default parameters. The
// reference model treats a tile as a queue of words. The k-th word that
// leaves the FIFO carries tag (k / cols, k % cols). The tile completes
// when k reaches rows*cols.
// ---------------------------------------------------------------------------
module tb_glb_mcast_driver;

  localparam int DW    = 16;
  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int DEPTH = 4;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [2:0]    cfg_rows  = '0;
  logic [2:0]    cfg_cols  = '0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data   = '0;
  logic          bus_valid;
  logic          bus_ready = 1'b0;
  logic [DW-1:0] bus_data;
  logic [1:0]    bus_row_id;
  logic [1:0]    bus_col_id;
  logic          busy;
  logic          done;
`ifdef GLB_DRV_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  glb_mcast_driver #(
    .DATA_WIDTH (DW),
    .NUM_ROW    (NR),
    .NUM_COL    (NC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .cfg_rows   (cfg_rows),
    .cfg_cols   (cfg_cols),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_data   (bus_data),
    .bus_row_id (bus_row_id),
    .bus_col_id (bus_col_id),
    .busy       (busy),
    .done       (done)
`ifdef GLB_DRV_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmp_cnt++;
    assert (observed === expected) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic iv,
                               input logic [DW-1:0] din, input logic br);
    start     = s;
    abort     = a;
    in_valid  = iv;
    in_data   = din;
    bus_ready = br;
  endtask

  // Advance one clock. Samples are taken 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_busy"},      32'(busy),       32'd0);
    checkOutput({tag, "_done"},      32'(done),       32'd0);
    checkOutput({tag, "_in_ready"},  32'(in_ready),   32'd0);
    checkOutput({tag, "_bus_valid"}, 32'(bus_valid),  32'd0);
    checkOutput({tag, "_row"},       32'(bus_row_id), 32'd0);
    checkOutput({tag, "_col"},       32'(bus_col_id), 32'd0);
  endtask

  // Runs one tile against the queue model. Inputs are randomized, and
  // stray start pulses with random sizes are injected during the run; the
  // design must ignore them. With abort_after > 0, abort is raised once
  // that many words have left on the bus.
  task automatic run_tile(input int rows, input int cols, input int in_pct,
                          input int rdy_pct, input int seq_base,
                          input int abort_after);
    logic [DW-1:0] q[$];
    int            total;
    int            acc;
    int            k;
    int            cyc;
    bit            running;
    bit            done_next;
    bit            finished;
    bit            exp_ir;
    bit            exp_bv;
    bit            iv;
    bit            br;
    bit            s;
    logic [DW-1:0] din;
    logic [31:0]   stall_exp;
    total     = rows * cols;
    acc       = 0;
    k         = 0;
    cyc       = 0;
    running   = 1'b1;
    done_next = 1'b0;
    finished  = 1'b0;
    stall_exp = '0;
    cfg_rows  = 3'(rows);
    cfg_cols  = 3'(cols);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    while (cyc < 4000 && !finished) begin
      exp_ir = running && (q.size() < DEPTH) && (acc < total);
      exp_bv = running && (q.size() > 0);
      checkOutput("in_ready",  32'(in_ready),  32'(exp_ir));
      checkOutput("bus_valid", 32'(bus_valid), 32'(exp_bv));
      checkOutput("busy",      32'(busy),      32'(running));
      checkOutput("done",      32'(done),      32'(done_next));
      if (exp_bv) begin
        checkOutput("bus_data", 32'(bus_data),   32'(q[0]));
        checkOutput("row_id",   32'(bus_row_id), 32'(k / cols));
        checkOutput("col_id",   32'(bus_col_id), 32'(k % cols));
      end
      if (done_next) begin
        finished = 1'b1;
      end else if (abort_after > 0 && k == abort_after) begin
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check_quiet("abort");
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check_quiet("post_abort");
        return;
      end else begin
        iv  = ($urandom_range(99) < in_pct);
        br  = ($urandom_range(99) < rdy_pct);
        s   = ($urandom_range(7) == 0);
        din = (seq_base != 0) ? DW'(seq_base + acc) : DW'($urandom);
        if (s) begin
          cfg_rows = 3'($urandom_range(4));
          cfg_cols = 3'($urandom_range(4));
        end
        applyStimulus(s, 1'b0, iv, din, br);
        if (iv && exp_ir) begin
          q.push_back(din);
          acc++;
        end
        if (exp_bv && !br && stall_exp != '1) stall_exp++;
        if (exp_bv && br) begin
          void'(q.pop_front());
          k++;
          if (k == total) begin
            running   = 1'b0;
            done_next = 1'b1;
          end
        end
        tick();
        cyc++;
      end
    end
    if (!finished) checkOutput("tile_timeout", 32'd0, 32'd1);
    // After completion, further words must be refused and done must not
    // repeat.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
    tick();
    check_quiet("after_done");
`ifdef GLB_DRV_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, stall_exp);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int nacc;
    // The reset state is visible while reset is asserted.
    #1;
    check_quiet("reset");
    checkOutput("reset_bus_data", 32'(bus_data), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    $display("[TB] basic 2x3 tile, words 0x11..0x16");
    run_tile(2, 3, 100, 100, 16'h11, 0);

    $display("[TB] FIFO fill with the bus stalled");
    cfg_rows = 3'd4;
    cfg_cols = 3'd4;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, DW'(16'hA0 + i), 1'b0);
      if (in_ready) nacc++;
      tick();
    end
    checkOutput("fill_accepted",  32'(nacc),      32'd4);
    checkOutput("fill_in_ready",  32'(in_ready),  32'd0);
    checkOutput("fill_bus_valid", 32'(bus_valid), 32'd1);
    checkOutput("fill_bus_data",  32'(bus_data),  32'h00A0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    check_quiet("fill_abort");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] 1x1 tile");
    run_tile(1, 1, 100, 100, 0, 0);

    $display("[TB] abort after 3 of 6, then restart");
    run_tile(2, 3, 100, 100, 0, 3);
    run_tile(2, 3, 100, 100, 0, 0);

    $display("[TB] start with zero cfg_cols is ignored");
    cfg_rows = 3'd2;
    cfg_cols = 3'd0;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
    tick();
    check_quiet("zero_cfg");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
    tick();
    check_quiet("zero_cfg2");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] randomized tiles");
    for (int t = 0; t < 12; t++) begin
      run_tile(int'($urandom_range(NR, 1)), int'($urandom_range(NC, 1)),
               int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, 0);
    end

    $display("[TB] reset mid-tile");
    cfg_rows = 3'd3;
    cfg_cols = 3'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
      tick();
    end
    rstn = 1'b0;
    #1;
    check_quiet("mid_reset");
    checkOutput("mid_reset_bus_data", 32'(bus_data), 32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("post_reset");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    run_tile(4, 4, 80, 60, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
